// File: rtl/raven_uno_pkg.sv
// Shared types for the univariate (div/exp/log) normalize/denormalize path.
// The issue-side normalizer uses the same tag layout.
package raven_uno_pkg;

  typedef enum logic [1:0] {
    GEMM = 2'b00,
    DIV  = 2'b01,
    EXP  = 2'b10,
    LOG  = 2'b11
  } uno_op_e;

  // round(ln2 * 2^10); tied to a 10-bit fraction.
  localparam int LN2_Q = 710;

  typedef struct packed {
    uno_op_e            op;
    logic signed [5:0]  e;
  } uno_tag_t;

endpackage

// File: rtl/sat_shift.sv
// Signed bidirectional shifter: positive amount shifts left with saturation,
// negative amount is an arithmetic right shift (truncates toward -inf).
module sat_shift #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] data_i,
  input  logic signed [5:0]   amt_i,
  output logic signed [W-1:0] res_o,
  output logic                sat_o
);

  localparam logic signed [W+31:0] SHL_MAX = {{33{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W+31:0] SHL_MIN = {{33{1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W+31:0] shl;
  logic        [6:0]    mag;

  // The wide left shift holds any 31-bit shift exactly, so overflow is a range check.
  assign shl = (W+32)'(data_i) <<< amt_i[4:0];
  assign mag = 7'd0 - 7'(amt_i);

  always_comb begin
    res_o = data_i;
    sat_o = 1'b0;
    if (amt_i[5]) begin
      if (mag >= 7'(W)) res_o = {W{data_i[W-1]}};
      else              res_o = data_i >>> mag;
    end else if (amt_i != 6'sd0) begin
      if (shl > SHL_MAX) begin
        res_o = OUT_MAX;
        sat_o = 1'b1;
      end else if (shl < SHL_MIN) begin
        res_o = OUT_MIN;
        sat_o = 1'b1;
      end else begin
        res_o = shl[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uno_denorm.sv
// Return end of the operand-normalization path: pairs PE results with queued
// issue tags in order and undoes the normalization scaling.
module uno_denorm
  import raven_uno_pkg::*;
#(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 1 + INT_BW + FRA_BW,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tag_valid_i,
  output logic                     tag_ready_o,
  input  logic [1:0]               tag_uno_i,
  input  logic signed [5:0]        tag_exp_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic signed [MUL_BW-1:0] res_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [MUL_BW-1:0] out_o,
  output logic                     sat_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic signed [MUL_BW+6:0] LN2_W   = (MUL_BW+7)'(LN2_Q);
  localparam logic signed [MUL_BW+7:0] LOG_MAX = {{9{1'b0}}, {(MUL_BW-1){1'b1}}};
  localparam logic signed [MUL_BW+7:0] LOG_MIN = {{9{1'b1}}, {(MUL_BW-1){1'b0}}};

  uno_tag_t             tags_q [DEPTH];
  uno_tag_t             tag_in;
  uno_tag_t             head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 push, pop;
  logic                 out_valid_q, out_valid_d, sat_q, sat_d;
  logic signed [MUL_BW-1:0] out_q, out_d;
  logic signed [MUL_BW-1:0] shift_res, result;
  logic                 shift_sat, result_sat;
  logic signed [MUL_BW+6:0] ln_prod;
  logic signed [MUL_BW+7:0] ln_diff;

  assign tag_in.op = uno_op_e'(tag_uno_i);
  assign tag_in.e  = tag_exp_i;
  assign head      = tags_q[rd_ptr_q];

  // Push is gated on not-full alone, so a same-cycle pop never frees a slot early.
  assign tag_ready_o = rst_n && (count_q != FULL_CNT);
  assign res_ready_o = rst_n && (count_q != '0) && (!out_valid_q || out_ready_i);
  assign push = tag_valid_i && tag_ready_o;
  assign pop  = res_valid_i && res_ready_o;

  sat_shift #(.W(MUL_BW)) u_sat_shift (
    .data_i (res_i),
    .amt_i  (head.e),
    .res_o  (shift_res),
    .sat_o  (shift_sat)
  );

  assign ln_prod = (MUL_BW+7)'(head.e) * LN2_W;
  assign ln_diff = (MUL_BW+8)'(res_i) - (MUL_BW+8)'(ln_prod);

  always_comb begin
    result     = res_i;
    result_sat = 1'b0;
    case (head.op)
      DIV, EXP: begin
        result     = shift_res;
        result_sat = shift_sat;
      end
      LOG: begin
        if (ln_diff > LOG_MAX) begin
          result     = LOG_MAX[MUL_BW-1:0];
          result_sat = 1'b1;
        end else if (ln_diff < LOG_MIN) begin
          result     = LOG_MIN[MUL_BW-1:0];
          result_sat = 1'b1;
        end else begin
          result = ln_diff[MUL_BW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    sat_d       = sat_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_d       = result;
      sat_d       = result_sat;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tags_q[wr_ptr_q] <= tag_in;
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign sat_o       = sat_q;

endmodule
